// File: rtl/img_stream_pkg.sv
// Shared constants for the image stream source: FSM state encodings,
// default image geometry and the address-width helper.
package img_stream_pkg;

    localparam int DEF_PIXEL_BITS = 8;
    localparam int DEF_IMG_WIDTH  = 28;
    localparam int DEF_IMG_HEIGHT = 28;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_GAP    = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    // Bits needed to index 'value' items, never less than one bit.
    function automatic int bits_for(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/frame_store.sv
// Pixel frame store: one synchronous write port and one asynchronous read port.
// Out-of-range write addresses are dropped; out-of-range reads return zero.
module frame_store #(
    parameter int DEPTH     = 16,
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 i_wr_en,
    input  logic [ADDR_BITS-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]     i_wr_data,
    input  logic [ADDR_BITS-1:0] i_rd_addr,
    output logic [WIDTH-1:0]     o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en && (int'(i_wr_addr) < DEPTH)) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = (int'(i_rd_addr) < DEPTH) ? r_mem[i_rd_addr] : '0;

endmodule

// File: rtl/image_stream_source.sv
// Streams frames from an internal store in raster order with sof/eol/eof
// markers, optional inter-frame gap, loop mode and graceful stop.
module image_stream_source
    import img_stream_pkg::*;
#(
    parameter int PIXEL_BITS = DEF_PIXEL_BITS,
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int NUM_FRAMES = 4,
    parameter int GAP_CYCLES = 16,
    parameter int ADDR_BITS  = bits_for(NUM_FRAMES * IMG_WIDTH * IMG_HEIGHT),
    parameter int FRAME_BITS = bits_for(NUM_FRAMES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [PIXEL_BITS-1:0] wr_data,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop_en,
    input  logic [FRAME_BITS-1:0] frame_count,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [PIXEL_BITS-1:0] m_data,
    output logic                  m_sof,
    output logic                  m_eol,
    output logic                  m_eof,
    output logic [FRAME_BITS-1:0] frame_idx,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            dbg_state
);

    localparam int DEPTH    = NUM_FRAMES * IMG_WIDTH * IMG_HEIGHT;
    localparam int COL_BITS = bits_for(IMG_WIDTH);
    localparam int ROW_BITS = bits_for(IMG_HEIGHT);
    localparam int GAP_BITS = bits_for(GAP_CYCLES + 1);

    logic [1:0]            r_state;
    logic [COL_BITS-1:0]   r_col;
    logic [ROW_BITS-1:0]   r_row;
    logic [FRAME_BITS-1:0] r_frame;
    logic [FRAME_BITS-1:0] r_count;
    logic [FRAME_BITS-1:0] r_frame_idx;
    logic [ADDR_BITS-1:0]  r_rd_addr;
    logic [GAP_BITS-1:0]   r_gap_cnt;
    logic                  r_loop;
    logic                  r_stop_seen;
    logic                  r_valid;
    logic                  r_sof;
    logic                  r_eol;
    logic                  r_eof;
    logic [PIXEL_BITS-1:0] r_data;

    logic [PIXEL_BITS-1:0] w_rd_data;
    logic [FRAME_BITS-1:0] w_count_clamped;
    logic                  w_xfer;
    logic                  w_eof_xfer;
    logic                  w_last_frame;
    logic                  w_end_stream;
    logic                  w_stream_load;
    logic                  w_gap_load;
    logic                  w_load;
    logic                  w_first_pix;
    logic                  w_last_col;
    logic                  w_last_row;
    logic                  w_frame_wrap;
    logic                  w_gap_end;

    frame_store #(
        .DEPTH     (DEPTH),
        .WIDTH     (PIXEL_BITS),
        .ADDR_BITS (ADDR_BITS)
    ) u_store (
        .clk       (clk),
        .i_wr_en   (wr_en && !busy),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (r_rd_addr),
        .o_rd_data (w_rd_data)
    );

    // Valid/ready: a pixel transfers on a cycle where m_valid && m_ready; once
    // m_valid is raised, data and flags hold until that transfer happens.
    assign w_xfer          = r_valid && m_ready;
    assign w_eof_xfer      = w_xfer && r_eof;
    assign w_count_clamped = (frame_count > FRAME_BITS'(NUM_FRAMES)) ? FRAME_BITS'(NUM_FRAMES) : frame_count;
    assign w_last_frame    = !r_loop && (r_frame_idx == r_count - FRAME_BITS'(1));
    assign w_end_stream    = r_stop_seen || stop || w_last_frame;
    assign w_first_pix     = (r_col == '0) && (r_row == '0);
    assign w_last_col      = (r_col == COL_BITS'(IMG_WIDTH - 1));
    assign w_last_row      = (r_row == ROW_BITS'(IMG_HEIGHT - 1));
    assign w_frame_wrap    = (r_frame == r_count - FRAME_BITS'(1));
    assign w_gap_end       = (r_gap_cnt == GAP_BITS'(GAP_CYCLES - 1));

    // An eof transfer that ends the stream or enters GAP must not pull the next pixel.
    assign w_stream_load = (r_state == ST_STREAM) && (!r_valid || m_ready) &&
                           !(w_eof_xfer && (w_end_stream || (GAP_CYCLES != 0)));
    assign w_gap_load    = (r_state == ST_GAP) && !stop && w_gap_end;
    assign w_load        = w_stream_load || w_gap_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_frame     <= '0;
            r_count     <= '0;
            r_frame_idx <= '0;
            r_rd_addr   <= '0;
            r_gap_cnt   <= '0;
            r_loop      <= 1'b0;
            r_stop_seen <= 1'b0;
            r_valid     <= 1'b0;
            r_sof       <= 1'b0;
            r_eol       <= 1'b0;
            r_eof       <= 1'b0;
            r_data      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_col       <= '0;
                        r_row       <= '0;
                        r_frame     <= '0;
                        r_rd_addr   <= '0;
                        r_gap_cnt   <= '0;
                        r_stop_seen <= 1'b0;
                        r_loop      <= loop_en;
                        r_count     <= w_count_clamped;
                        r_state     <= (frame_count == '0) ? ST_FINISH : ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_eof_xfer && w_end_stream) begin
                        r_valid <= 1'b0;
                        r_state <= ST_FINISH;
                    end else if (w_eof_xfer && (GAP_CYCLES != 0)) begin
                        r_valid   <= 1'b0;
                        r_gap_cnt <= '0;
                        r_state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (stop) begin
                        r_state <= ST_FINISH;
                    end else if (w_gap_end) begin
                        r_state <= ST_STREAM;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_BITS'(1);
                    end
                end
                ST_FINISH: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase

            if (stop && ((r_state == ST_STREAM) || (r_state == ST_GAP))) begin
                r_stop_seen <= 1'b1;
            end else if (w_load && w_first_pix) begin
                r_stop_seen <= 1'b0;
            end

            // Counters always point at the next pixel to load.
            if (w_load) begin
                r_valid   <= 1'b1;
                r_data    <= w_rd_data;
                r_sof     <= w_first_pix;
                r_eol     <= w_last_col;
                r_eof     <= w_last_col && w_last_row;
                r_rd_addr <= (w_last_col && w_last_row && w_frame_wrap) ? '0 : r_rd_addr + ADDR_BITS'(1);
                if (w_first_pix) begin
                    r_frame_idx <= r_frame;
                end
                if (!w_last_col) begin
                    r_col <= r_col + COL_BITS'(1);
                end else begin
                    r_col <= '0;
                    if (!w_last_row) begin
                        r_row <= r_row + ROW_BITS'(1);
                    end else begin
                        r_row   <= '0;
                        r_frame <= w_frame_wrap ? '0 : r_frame + FRAME_BITS'(1);
                    end
                end
            end
        end
    end

    assign m_valid   = r_valid;
    assign m_data    = r_data;
    assign m_sof     = r_sof;
    assign m_eol     = r_eol;
    assign m_eof     = r_eof;
    assign frame_idx = r_frame_idx;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_FINISH);
    assign dbg_state = r_state;

endmodule
